// File: rtl/timer_counter.sv
// Programmable down-counter with CTRL/PRESET/COUNT registers and an interrupt.
// Optional prescaler enabled by defining TC_PRESCALE_EN.
module timer_counter #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        mode1;
  logic        tick;
  logic        unused;

  assign mode1  = (ctrl[2:1] == 2'b01);
  assign irq    = irq_flag & ctrl[3];
  assign unused = ^din[31:4];

`ifdef TC_PRESCALE_EN
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] ps;

  assign tick = (ps == PS_LAST);
`else
  // Without the prescaler every CNT cycle is a tick; legal PRESCALE is >= 1.
  assign tick = (PRESCALE >= 1);
`endif

  // Counter FSM plus bus writes; a CTRL write overrides FSM updates to CTRL.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
`ifdef TC_PRESCALE_EN
      ps       <= '0;
`endif
    end else begin
      if (we && addr == 2'd0) begin
        irq_flag <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (ctrl[0]) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
`ifdef TC_PRESCALE_EN
          ps    <= '0;
`endif
        end
        CNT: begin
          if (!ctrl[0]) begin
            state <= IDLE;
          end else if (tick) begin
`ifdef TC_PRESCALE_EN
            ps <= '0;
`endif
            if (count <= 32'd1) begin
              count    <= '0;
              state    <= INT;
              irq_flag <= 1'b1;
            end else begin
              count <= count - 32'd1;
            end
          end else begin
`ifdef TC_PRESCALE_EN
            ps <= ps + 16'd1;
`endif
          end
        end
        INT: begin
          if (mode1) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (we) begin
        unique case (addr)
          2'd0:    ctrl   <= din[3:0];
          2'd1:    preset <= din;
          default: ;
        endcase
      end
    end
  end

  // Combinational read mux; reserved word reads as zero.
  always_comb begin
    dout = '0;
    unique case (addr)
      2'd0:    dout = {28'd0, ctrl};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter (default build).
// Hand-computed vectors for reset, mode 0, mode 1, PRESET=0 and mid-count events.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  logic [31:0] m1_cnt [9]  = '{3, 2, 1, 0, 0, 3, 2, 1, 0};
  logic        m1_irq [9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
  logic [31:0] m1m_cnt [6] = '{0, 3, 2, 1, 0, 0};

  initial begin
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'd0;
    din   = '0;
    step(2);
    reset = 1'b0;

    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_preset", 2'd1, 32'h0);
    rd("rst_count", 2'd2, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // Mode 0, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    step(2);
    rd("m0_load", 2'd2, 32'd5);
    chk_irq("m0_irq_lo", 1'b0);
    for (int k = 4; k >= 1; k--) begin
      step();
      rd($sformatf("m0_cnt%0d", k), 2'd2, 32'(k));
      chk_irq("m0_irq_cnt", 1'b0);
    end
    step();
    rd("m0_zero", 2'd2, 32'd0);
    chk_irq("m0_irq_hi", 1'b1);
    rd("m0_ctrl_int", 2'd0, 32'h9);
    step();
    rd("m0_ctrl_done", 2'd0, 32'h8);
    chk_irq("m0_irq_hold", 1'b1);
    step(3);
    chk_irq("m0_irq_hold2", 1'b1);
    rd("m0_cnt_hold", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    chk_irq("m0_irq_clr", 1'b0);

    // Mode 1, PRESET=3, IM=1
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    step();
    for (int i = 0; i < 9; i++) begin
      step();
      rd($sformatf("m1_cnt%0d", i), 2'd2, m1_cnt[i]);
      chk_irq($sformatf("m1_irq%0d", i), m1_irq[i]);
    end
    // Mask the interrupt; counting continues
    wr(2'd0, 32'h3);
    for (int i = 0; i < 6; i++) begin
      rd($sformatf("m1m_cnt%0d", i), 2'd2, m1m_cnt[i]);
      chk_irq($sformatf("m1m_irq%0d", i), 1'b0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;

    // PRESET=0 expires without wrapping
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    chk_irq("p0_irq_e0", 1'b0);
    step();
    chk_irq("p0_irq_e1", 1'b0);
    step();
    chk_irq("p0_irq_e2", 1'b0);
    rd("p0_cnt_e2", 2'd2, 32'd0);
    step();
    chk_irq("p0_irq_e3", 1'b1);
    rd("p0_cnt_e3", 2'd2, 32'd0);
    step();
    rd("p0_cnt_e4", 2'd2, 32'd0);
    rd("p0_ctrl_e4", 2'd0, 32'h8);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Mid-count disable, PRESET write during CNT, reset mid-count
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    step(12);
    rd("mc_cnt10", 2'd2, 32'd10);
    wr(2'd0, 32'h8);
    rd("mc_cnt_next", 2'd2, 32'd9);
    step(4);
    rd("mc_frozen", 2'd2, 32'd9);
    wr(2'd2, 32'h1234);
    rd("mc_ro_count", 2'd2, 32'd9);
    rd("mc_addr3", 2'd3, 32'd0);
    wr(2'd0, 32'h9);
    step(2);
    rd("mc_reload", 2'd2, 32'd20);
    wr(2'd1, 32'd7);
    step();
    rd("mc_pre_ignored", 2'd2, 32'd18);
    rd("mc_preset_rd", 2'd1, 32'd7);
    step(14);
    rd("mc_cnt4", 2'd2, 32'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd("mr_ctrl", 2'd0, 32'h0);
    rd("mr_preset", 2'd1, 32'h0);
    rd("mr_count", 2'd2, 32'h0);
    chk_irq("mr_irq", 1'b0);
    step(3);
    rd("mr_idle", 2'd2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
